bias_sequencer: RTL and testbench

BIAS_SEQUENCER -- requirements
Module: bias_sequencer

---
 rtl/bias_sequencer.sv | 74 +++++++
 tb/tb_bias_sequencer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/bias_sequencer.sv
// bias_sequencer: adds the selected group's bias to each adder-tree beat, then saturates to 18 bits and optionally applies ReLU.
module bias_sequencer #(
  parameter int N_adder_tree = 16,
  parameter int N_GROUPS     = 64,
  parameter int GW           = 6,
  parameter bit RELU         = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [N_adder_tree*18-1:0]  in_data,
  output logic [GW-1:0]               bias_sel,
  input  logic [N_adder_tree*18-1:0]  bias_q,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [N_adder_tree*18-1:0]  out_data,
  output logic                        busy,
  output logic                        done
);
  localparam int W = N_adder_tree * 18;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t r_state, w_next;
  logic [GW-1:0] r_grp;
  logic          r_out_valid;
  logic [W-1:0]  r_out_data, w_res;
  logic          w_acc, w_xfer, w_last, w_start;
  assign w_xfer   = r_out_valid & out_ready;
  assign in_ready = (r_state == RUN) & (~r_out_valid | out_ready);
  assign w_acc    = in_valid & in_ready;
  assign w_last   = r_grp == GW'(N_GROUPS - 1);
  assign w_start  = (r_state == IDLE) & start;
  assign bias_sel  = r_grp;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign busy      = r_state != IDLE;
  assign done      = (r_state == DRAIN) & w_xfer;
  always_comb begin
    w_next = r_state;
    w_next = w_start ? RUN :
             (r_state == RUN && w_acc && w_last) ? DRAIN :
             (r_state == DRAIN && w_xfer) ? IDLE : r_state;
  end
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_grp       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      if (w_start)    r_grp <= '0;
      else if (w_acc) r_grp <= w_last ? '0 : r_grp + GW'(1);
      if (w_acc) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_res;
      end else if (w_xfer) begin
        r_out_valid <= 1'b0;
      end
    end
  end
  // 19-bit sum overflows 18 bits exactly when its top two bits differ
  for (genvar i = 0; i < N_adder_tree; i++) begin : g_lane
    logic signed [18:0] w_sum;
    logic        [17:0] w_sat;
    assign w_sum = $signed({in_data[18*i+17], in_data[18*i +: 18]}) +
                   $signed({bias_q[18*i+17], bias_q[18*i +: 18]});
    assign w_sat = (w_sum[18] != w_sum[17]) ? {w_sum[18], {17{~w_sum[18]}}} : w_sum[17:0];
    assign w_res[18*i +: 18] = (RELU && w_sat[17]) ? 18'd0 : w_sat;
  end
endmodule

// File: tb/tb_bias_sequencer.sv
// tb_bias_sequencer: directed scenarios with a cycle model and an expected-output queue.
module tb_bias_sequencer;
  localparam int NL = 2, NG = 4, GW = 2;
  localparam bit RELU = 1;
  logic clk = 0, rst = 1, start = 0, in_valid = 0, out_ready = 1;
  logic in_ready, out_valid, busy, done;
  logic [NL*18-1:0] in_data = '0, bias_q, out_data;
  logic [GW-1:0] bias_sel;
  logic [35:0] bank [NG];
  assign bias_q = bank[bias_sel];
  always #5 clk = ~clk;

  bias_sequencer #(.N_adder_tree(NL), .N_GROUPS(NG), .GW(GW), .RELU(RELU)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .bias_sel(bias_sel), .bias_q(bias_q), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .busy(busy), .done(done)
  );

  int n_chk = 0, n_pass = 0, n_done = 0, n_tick = 0, m_st = 0, m_grp = 0;
  bit m_ov = 0, last_acc = 0;
  logic [35:0] exp_q [$];

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [17:0] ref_lane(logic [17:0] a, logic [17:0] b);
    int s;
    s = int'($signed(a)) + int'($signed(b));
    if (s > 131071) s = 131071;
    if (s < -131072) s = -131072;
    if (RELU && s < 0) s = 0;
    return s[17:0];
  endfunction

  task automatic tick();
    bit acc, xfer, dn;
    #1;
    chk("in_ready", in_ready, m_st == 1 && (!m_ov || out_ready));
    chk("out_valid", out_valid, m_ov);
    chk("busy", busy, m_st != 0);
    chk("bias_sel", bias_sel, m_grp);
    dn = m_st == 2 && m_ov && out_ready;
    chk("done", done, dn);
    if (m_ov && exp_q.size() > 0) chk("out_data", out_data, exp_q[0]);
    n_done += int'(done);
    acc = in_valid && m_st == 1 && (!m_ov || out_ready);
    xfer = m_ov && out_ready;
    last_acc = acc;
    if (rst) begin
      m_st = 0; m_grp = 0; m_ov = 0; exp_q.delete();
    end else begin
      if (xfer) void'(exp_q.pop_front());
      if (acc) begin
        exp_q.push_back({ref_lane(in_data[35:18], bank[m_grp][35:18]),
                         ref_lane(in_data[17:0], bank[m_grp][17:0])});
        if (m_grp == NG - 1) begin m_grp = 0; m_st = 2; end
        else m_grp++;
      end
      m_ov = acc || (m_ov && !out_ready);
      if (m_st == 0 && start) begin m_st = 1; m_grp = 0; end
      else if (dn) m_st = 0;
    end
    n_tick++;
    @(posedge clk); #1;
  endtask

  task automatic set_in(int l0, int l1);
    in_data = {l1[17:0], l0[17:0]};
  endtask

  task automatic beat(int l0, int l1);
    in_valid = 1;
    set_in(l0, l1);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (last_acc) break;
    end
    chk("accept_timeout", last_acc, 1);
  endtask

  task automatic drain();
    in_valid = 0;
    for (int i = 0; i < 20 && m_st != 0; i++) tick();
    chk("drain_timeout", m_st, 0);
  endtask

  task automatic set_bank(int g, int l0, int l1);
    bank[g] = {l1[17:0], l0[17:0]};
  endtask

  task automatic default_banks();
    for (int g = 0; g < NG; g++) set_bank(g, -30, g * 7);
  endtask

  task automatic pulse_start();
    start = 1;
    tick();
    start = 0;
  endtask

  initial begin
    int t0;
    default_banks();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_bias_sel", bias_sel, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_done", done, 0);
    rst = 0;
    tick();
    // basic pass: 100 + (-30) = 70 on lane 0
    pulse_start();
    for (int g = 0; g < NG; g++) beat(100, 5 + g);
    drain();
    chk("s1_done_count", n_done, 1);
    // saturation and rectification
    set_bank(0, 200, 3);
    set_bank(1, -200, -3);
    set_bank(2, 0, -131072);
    set_bank(3, 1, 131071);
    pulse_start();
    beat(131000, 1000);
    beat(-131000, 2);
    beat(131071, 5);
    beat(-5, 131071);
    drain();
    chk("s2_done_count", n_done, 2);
    // downstream stall after the first beat
    default_banks();
    pulse_start();
    beat(10, 20);
    out_ready = 0;
    set_in(11, 21);
    repeat (5) tick();
    out_ready = 1;
    beat(11, 21);
    beat(12, 22);
    beat(13, 23);
    drain();
    chk("s3_done_count", n_done, 3);
    // start during RUN is ignored
    pulse_start();
    beat(1, 1);
    beat(2, 2);
    start = 1;
    beat(3, 3);
    start = 0;
    beat(4, 4);
    drain();
    chk("s4_done_count", n_done, 4);
    // reset mid-pass overrides start and an accept
    pulse_start();
    beat(7, 7);
    beat(8, 8);
    set_in(9, 9);
    rst = 1;
    start = 1;
    tick();
    rst = 0;
    start = 0;
    in_valid = 0;
    chk("s5_out_valid", out_valid, 0);
    chk("s5_bias_sel", bias_sel, 0);
    chk("s5_busy", busy, 0);
    chk("s5_out_data", out_data, 0);
    repeat (3) tick();
    chk("s5_no_done", n_done, 4);
    pulse_start();
    for (int g = 0; g < NG; g++) beat(-40 + g, 50 - g);
    drain();
    chk("s5_done_count", n_done, 5);
    // streaming at one beat per cycle
    pulse_start();
    t0 = n_tick;
    for (int g = 0; g < NG; g++) beat(1000 * g, -g);
    chk("s6_cycles", n_tick - t0, NG);
    drain();
    chk("s6_done_count", n_done, 6);
    chk("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
